// File: rtl/measure_tx_sched_pkg.sv
// Shared definitions for the measurement-probe TX scheduler: FSM encoding,
// XGMII control bytes, protocol constants and frame-length limits.
package measure_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_BODY = 3'd2,
    ST_TERM = 3'd3,
    ST_IFG  = 3'd4
  } state_t;

  localparam logic [7:0]  XGMII_IDLE     = 8'h07;
  localparam logic [7:0]  XGMII_START    = 8'hFB;
  localparam logic [7:0]  XGMII_TERM     = 8'hFD;
  localparam logic [7:0]  XGMII_PRE      = 8'h55;
  localparam logic [7:0]  XGMII_SFD      = 8'hD5;
  localparam logic [63:0] XGMII_IDLE_WORD = {8{XGMII_IDLE}};

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TTL         = 8'h40;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam logic [15:0] MIN_FRAME_LEN  = 16'd64;
  localparam logic [15:0] MAX_FRAME_LEN  = 16'd1520;

  // Clamp the requested length and return the number of 8-byte body words.
  function automatic logic [7:0] body_words(input logic [15:0] len);
    logic [15:0] l;
    if (len < MIN_FRAME_LEN) begin
      l = MIN_FRAME_LEN;
    end else if (len > MAX_FRAME_LEN) begin
      l = MAX_FRAME_LEN;
    end else begin
      l = len;
    end
    return 8'(l >> 3);
  endfunction

endpackage

// File: rtl/measure_tx_word.sv
// Combinational XGMII word generator: maps (state, body word index, timestamp)
// onto the 64-bit data / 8-bit control lanes of the probe frame.
module measure_tx_word
  import measure_tx_sched_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = 48'h003776_000101,
  parameter logic [47:0] DST_MAC   = 48'hffffff_ffffff,
  parameter logic [31:0] SRC_IP    = 32'h0A00_1569,
  parameter logic [31:0] DST_IP    = 32'h0A00_156A,
  parameter logic [15:0] UDP_DPORT = 16'd3422,
  parameter logic [31:0] MAGIC     = 32'h0
) (
  input  state_t      state,
  input  logic [7:0]  word_idx,
  input  logic [31:0] ts,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  // First 56 frame bytes (words 1..7), byte 0 in the top bits; checksums,
  // lengths, IDs and the source port stay zero.
  logic [447:0] hdr_s;
  assign hdr_s = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, IP_VER_IHL, 8'h00, 48'h0,
                  IP_TTL, IP_PROTO_UDP, 16'h0, SRC_IP, DST_IP, 16'h0, UDP_DPORT,
                  32'h0, MAGIC, ts, 48'h0};

  // Lane selection per state; lane 0 carries the earliest byte on the wire.
  always_comb begin
    txd = XGMII_IDLE_WORD;
    txc = 8'hff;
    case (state)
      ST_SOF: begin
        txd = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
        txc = 8'h01;
      end
      ST_BODY: begin
        txc = 8'h00;
        txd = 64'h0;
        if ((word_idx >= 8'd1) && (word_idx <= 8'd7)) begin
          for (int lane = 0; lane < 8; lane++) begin
            txd[8*lane +: 8] = hdr_s[8*(55 - (8*(int'(word_idx) - 1) + lane)) +: 8];
          end
        end else begin
          txd = 64'h0;
        end
      end
      ST_TERM: begin
        txd = {{7{XGMII_IDLE}}, XGMII_TERM};
        txc = 8'hff;
      end
      default: begin
        txd = XGMII_IDLE_WORD;
        txc = 8'hff;
      end
    endcase
  end

endmodule

// File: rtl/measure_tx_sched.sv
// Burst sequencer for timestamped UDP probe frames on a 64-bit XGMII TX port.
// Optional feature macro: MEASURE_TX_STATS_EN adds the tx_frames counter output.
module measure_tx_sched
  import measure_tx_sched_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = 48'h003776_000101,
  parameter logic [47:0] DST_MAC   = 48'hffffff_ffffff,
  parameter logic [31:0] SRC_IP    = 32'h0A00_1569,
  parameter logic [31:0] DST_IP    = 32'h0A00_156A,
  parameter logic [15:0] UDP_DPORT = 16'd3422,
  parameter logic [31:0] MAGIC     = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] global_counter,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_len,
  input  logic [15:0] ifg_cycles,
  input  logic [31:0] frame_count,
  output logic        busy,
  output logic        done,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc
`ifdef MEASURE_TX_STATS_EN
  ,
  output logic [31:0] tx_frames
`endif
);

  logic [1:0]  rst_sync_q;
  logic        rst_int_n;
  state_t      state_q, state_d;
  logic [7:0]  nwords_q, nwords_d, word_q, word_d;
  logic [15:0] ifg_q, ifg_d, ifg_cnt_q, ifg_cnt_d, ifg_tgt_s;
  logic [31:0] count_q, count_d, sent_q, sent_d, ts_q, ts_d;
  logic        stop_pend_q, stop_pend_d, busy_q, busy_d, done_q, done_d;
  logic        burst_end_s;
  logic [63:0] txd_q, txd_s;
  logic [7:0]  txc_q, txc_s;
`ifdef MEASURE_TX_STATS_EN
  logic [31:0] tx_frames_q, tx_frames_d;
`endif

  // Reset asserts asynchronously but releases two clock edges later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  // Next-state logic; stop is only remembered once a burst is running.
  always_comb begin
    state_d     = state_q;
    nwords_d    = nwords_q;
    word_d      = word_q;
    ifg_d       = ifg_q;
    ifg_cnt_d   = ifg_cnt_q;
    count_d     = count_q;
    sent_d      = sent_q;
    ts_d        = ts_q;
    stop_pend_d = stop_pend_q | stop;
    done_d      = 1'b0;
    ifg_tgt_s   = (ifg_q == 16'd0) ? 16'd1 : ifg_q;
    burst_end_s = stop_pend_q || ((count_q != 32'd0) && (sent_q >= count_q));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SOF;
          nwords_d    = body_words(frame_len);
          ifg_d       = ifg_cycles;
          count_d     = frame_count;
          sent_d      = 32'd0;
          stop_pend_d = stop;
        end else begin
          stop_pend_d = 1'b0;
        end
      end
      ST_SOF: begin
        state_d = ST_BODY;
        word_d  = 8'd1;
        ts_d    = global_counter;
      end
      ST_BODY: begin
        if (word_q >= nwords_q) begin
          state_d = ST_TERM;
        end else begin
          word_d = word_q + 8'd1;
        end
      end
      ST_TERM: begin
        state_d   = ST_IFG;
        ifg_cnt_d = 16'd1;
        // Saturate so an unlimited burst never wraps back onto a small count.
        if (sent_q != 32'hffff_ffff) begin
          sent_d = sent_q + 32'd1;
        end else begin
          sent_d = sent_q;
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q >= ifg_tgt_s) begin
          if (burst_end_s) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_SOF;
          end
        end else begin
          ifg_cnt_d = ifg_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Outputs are generated from the next state so they register in step with it.
  measure_tx_word #(
    .SRC_MAC(SRC_MAC), .DST_MAC(DST_MAC), .SRC_IP(SRC_IP),
    .DST_IP(DST_IP), .UDP_DPORT(UDP_DPORT), .MAGIC(MAGIC)
  ) u_word (
    .state   (state_d),
    .word_idx(word_d),
    .ts      (ts_q),
    .txd     (txd_s),
    .txc     (txc_s)
  );

  // Sequencer and output registers.
  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      nwords_q    <= 8'd0;
      word_q      <= 8'd0;
      ifg_q       <= 16'd0;
      ifg_cnt_q   <= 16'd0;
      count_q     <= 32'd0;
      sent_q      <= 32'd0;
      ts_q        <= 32'd0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      txd_q       <= XGMII_IDLE_WORD;
      txc_q       <= 8'hff;
    end else begin
      state_q     <= state_d;
      nwords_q    <= nwords_d;
      word_q      <= word_d;
      ifg_q       <= ifg_d;
      ifg_cnt_q   <= ifg_cnt_d;
      count_q     <= count_d;
      sent_q      <= sent_d;
      ts_q        <= ts_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      txd_q       <= txd_s;
      txc_q       <= txc_s;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign xgmii_txd = txd_q;
  assign xgmii_txc = txc_q;

`ifdef MEASURE_TX_STATS_EN
  // One count per TERM word actually transmitted.
  always_comb begin
    tx_frames_d = tx_frames_q;
    if (state_q == ST_TERM) begin
      tx_frames_d = tx_frames_q + 32'd1;
    end else begin
      tx_frames_d = tx_frames_q;
    end
  end

  // Frame statistics register.
  always_ff @(posedge sys_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tx_frames_q <= 32'd0;
    end else begin
      tx_frames_q <= tx_frames_d;
    end
  end

  assign tx_frames = tx_frames_q;
`endif

endmodule

// File: tb/tb_measure_tx_sched.sv
// Self-checking bench for measure_tx_sched: a byte-level frame model predicts
// every XGMII word, busy and done; bursts mix directed and random settings.
`timescale 1ns/1ps
module tb_measure_tx_sched;

  localparam logic [47:0] SRC_MAC   = 48'h003776_000101;
  localparam logic [47:0] DST_MAC   = 48'hffffff_ffffff;
  localparam logic [31:0] SRC_IP    = 32'h0A00_1569;
  localparam logic [31:0] DST_IP    = 32'h0A00_156A;
  localparam logic [15:0] UDP_DPORT = 16'd3422;
  localparam logic [31:0] MAGIC     = 32'hC0DE_5A17;
  localparam logic [63:0] IDLE_W    = 64'h0707070707070707;
  localparam logic [63:0] SOF_W     = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W    = 64'h07070707070707FD;
  localparam logic [73:0] IDLE00    = {8'hff, IDLE_W, 2'b00};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [31:0] global_counter = 32'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_len = 16'd0;
  logic [15:0] ifg_cycles = 16'd0;
  logic [31:0] frame_count = 32'd0;
  logic        busy, done;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
`ifdef MEASURE_TX_STATS_EN
  logic [31:0] tx_frames;
`endif

  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  logic        gc_run = 1'b0;
  logic [31:0] gc_base = 32'd0;
  logic [31:0] gc_fixed = 32'd0;
  logic [31:0] exp_tx = 32'd0;
  logic [73:0] exp_q[$];

  measure_tx_sched #(
    .SRC_MAC(SRC_MAC), .DST_MAC(DST_MAC), .SRC_IP(SRC_IP),
    .DST_IP(DST_IP), .UDP_DPORT(UDP_DPORT), .MAGIC(MAGIC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .global_counter(global_counter),
    .start(start), .stop(stop), .frame_len(frame_len), .ifg_cycles(ifg_cycles),
    .frame_count(frame_count), .busy(busy), .done(done),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc)
`ifdef MEASURE_TX_STATS_EN
    , .tx_frames(tx_frames)
`endif
  );

  always #3 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got txc=%h txd=%h busy=%b done=%b, want txc=%h txd=%h busy=%b done=%b",
                tag, obs[73:66], obs[65:2], obs[1], obs[0], exp[73:66], exp[65:2], exp[1], exp[0]);
  endtask

  task automatic check_stats(input string tag);
`ifdef MEASURE_TX_STATS_EN
    total++;
    assert (tx_frames === exp_tx) passed++;
    else $error("FAIL %s tx_frames: got %0d want %0d", tag, tx_frames, exp_tx);
`else
    exp_tx = exp_tx;
`endif
  endtask

  task automatic step_obs(input string tag, input logic [73:0] exp);
    @(negedge sys_clk);
    cyc++;
    check(tag, {xgmii_txc, xgmii_txd, busy, done}, exp);
    global_counter = gc_run ? gc_base + 32'(cyc) : gc_fixed;
  endtask

  // Build one frame as a byte array from the header field offsets, then
  // pack eight bytes per word; followed by TERM and the gap.
  task automatic model_frame(input int eff, input int ifg, input logic [31:0] ts);
    logic [7:0]  fb [0:1519];
    logic [63:0] w;
    for (int i = 0; i < 1520; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = DST_MAC[8*(5-i) +: 8];
      fb[6 + i] = SRC_MAC[8*(5-i) +: 8];
    end
    fb[12] = 8'h08;
    fb[14] = 8'h45;
    fb[22] = 8'h40;
    fb[23] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      fb[26 + i] = SRC_IP[8*(3-i) +: 8];
      fb[30 + i] = DST_IP[8*(3-i) +: 8];
      fb[42 + i] = MAGIC[8*(3-i) +: 8];
      fb[46 + i] = ts[8*(3-i) +: 8];
    end
    fb[36] = UDP_DPORT[15:8];
    fb[37] = UDP_DPORT[7:0];
    exp_q.push_back({8'h01, SOF_W, 2'b10});
    for (int k = 0; k < eff / 8; k++) begin
      for (int l = 0; l < 8; l++) w[8*l +: 8] = fb[8*k + l];
      exp_q.push_back({8'h00, w, 2'b10});
    end
    exp_q.push_back({8'hff, TERM_W, 2'b10});
    for (int k = 0; k < ((ifg == 0) ? 1 : ifg); k++) exp_q.push_back({8'hff, IDLE_W, 2'b10});
  endtask

  // One burst: start from IDLE, compare every word until two cycles after done.
  task automatic run_burst(input string tag, input int len, input int ifg, input int cnt,
                           input int nframes, input int stop_at, input logic stop_with_start);
    int eff, fw, s0;
    logic [73:0] e;
    eff = (len < 64) ? 64 : ((len > 1520) ? 1520 : len);
    eff = (eff / 8) * 8;
    fw  = 2 + eff / 8 + ((ifg == 0) ? 1 : ifg);
    exp_q.delete();
    step_obs({tag, "/idle"}, IDLE00);
    frame_len   = 16'(len);
    ifg_cycles  = 16'(ifg);
    frame_count = 32'(cnt);
    start       = 1'b1;
    stop        = stop_with_start;
    s0          = cyc;
    for (int f = 0; f < nframes; f++)
      model_frame(eff, ifg, gc_run ? gc_base + 32'(s0 + 1 + f * fw) : gc_fixed);
    exp_q.push_back({8'hff, IDLE_W, 2'b01});
    exp_q.push_back(IDLE00);
    exp_q.push_back(IDLE00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      step_obs(tag, e);
      start = 1'b0;
      stop  = (i == stop_at);
    end
    stop = 1'b0;
    exp_tx = exp_tx + 32'(nframes);
    check_stats(tag);
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset", {xgmii_txc, xgmii_txd, busy, done}, IDLE00);
    check_stats("reset");
    sys_rst_n = 1'b1;
    step_obs("reset/sync", IDLE00);

    // Three 64-byte frames with a fixed timestamp source.
    gc_run = 1'b0;
    gc_fixed = 32'h12345678;
    run_burst("basic", 64, 12, 3, 3, -1, 1'b0);

    gc_run = 1'b1;
    gc_base = $urandom();
    run_burst("len30", 30, 2, 1, 1, -1, 1'b0);
    run_burst("len2000", 2000, 1, 1, 1, -1, 1'b0);
    run_burst("len100", 100, 0, 2, 2, -1, 1'b0);

    // Unlimited burst, stop in third frame's third body word (frame = 14 words).
    run_burst("stop", 72, 3, 0, 3, 2 * 14 + 3, 1'b0);
    run_burst("startstop", 64, 2, 5, 1, -1, 1'b1);

    stop = 1'b1;
    step_obs("idle_stop", IDLE00);
    stop = 1'b0;
    run_burst("five", 64, 1, 5, 5, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int len, ifg, cnt;
      len = int'($urandom_range(0, 1600));
      ifg = int'($urandom_range(0, 6));
      cnt = int'($urandom_range(1, 3));
      gc_base = $urandom();
      run_burst("rand", len, ifg, cnt, cnt, -1, 1'b0);
    end

    // Reset in the middle of a frame body.
    exp_q.delete();
    step_obs("rst/idle", IDLE00);
    frame_len = 16'd64; ifg_cycles = 16'd4; frame_count = 32'd0;
    start = 1'b1;
    model_frame(64, 4, gc_base + 32'(cyc + 1));
    for (int i = 0; i < 4; i++) begin
      step_obs("rst/pre", exp_q.pop_front());
      start = 1'b0;
    end
    #1 sys_rst_n = 1'b0;
    exp_tx = 32'd0;
    #1 check("rst/async", {xgmii_txc, xgmii_txd, busy, done}, IDLE00);
    step_obs("rst/held", IDLE00);
    check_stats("rst/held");
    sys_rst_n = 1'b1;
    step_obs("rst/sync", IDLE00);
    run_burst("post_rst", 64, 3, 1, 1, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
